// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning episode controller: action codes,
// FSM state encoding and the {x,y} state-field split.
package qlearn_pkg;

    localparam logic [1:0] ACT_LEFT  = 2'b00;  // y-1
    localparam logic [1:0] ACT_UP    = 2'b01;  // x-1
    localparam logic [1:0] ACT_RIGHT = 2'b10;  // y+1
    localparam logic [1:0] ACT_DOWN  = 2'b11;  // x+1

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fsm_state_t;

    // A state is {x,y}; each coordinate takes half of the state width.
    function automatic int unsigned field_w(input int unsigned state_w);
        return state_w / 2;
    endfunction

endpackage

// File: rtl/qlearn_hazard_sb.sv
// Shift-register scoreboard of in-flight Q write-backs; flags read-after-write
// hazards against the current and next state and reports when it drains.
module qlearn_hazard_sb
    import qlearn_pkg::*;
#(
    parameter int unsigned STATE_W = 6,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [STATE_W-1:0] push_state,
    input  logic [STATE_W-1:0] s,
    input  logic [STATE_W-1:0] ns,
    output logic               hazard,
    output logic               empty
);

    logic [DEPTH-1:0]   vld;
    logic [STATE_W-1:0] st [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                st[i] <= '0;
            end
        end else begin
            vld[0] <= push;
            st[0]  <= push_state;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                st[i]  <= st[i-1];
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld[i] && ((st[i] == s) || (st[i] == ns))) begin
                hazard = 1'b1;
            end
        end
    end

    // The last slot retires at this edge, so only the earlier slots can keep
    // the pipeline occupied into the next cycle.
    always_comb begin
        empty = 1'b1;
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            if (vld[i]) begin
                empty = 1'b0;
            end
        end
    end

endmodule

// File: rtl/qlearn_episode_ctrl.sv
// Episode sequencer for the 4-stage Q-learning update pipeline: random-action
// stepping on a clamped grid, hazard-stalled issue, episode drain and counting.
module qlearn_episode_ctrl
    import qlearn_pkg::*;
#(
    parameter int unsigned STATE_W     = 6,
    parameter int unsigned ACT_W       = 2,
    parameter int unsigned PIPE_DEPTH  = 4,
    parameter int unsigned START_STATE = 0,
    parameter int unsigned MAX_STEPS   = 255,
    parameter int unsigned NUM_EPIS    = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] goal_state,
    input  logic [ACT_W-1:0]   act_rand,
    input  logic               issue_ready,
    output logic               issue_valid,
    output logic [STATE_W-1:0] issue_s,
    output logic [ACT_W-1:0]   issue_a,
    output logic [STATE_W-1:0] issue_ns,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [CNT_W-1:0]   epi_cnt,
    output logic               busy,
    output logic               done
);

    localparam int unsigned        HALF      = field_w(STATE_W);
    localparam logic [STATE_W-1:0] START_S   = STATE_W'(START_STATE);
    localparam logic [CNT_W-1:0]   LAST_STEP = CNT_W'(MAX_STEPS - 1);
    localparam logic [CNT_W-1:0]   LAST_EPI  = CNT_W'(NUM_EPIS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [HALF-1:0]    XY_ONE    = HALF'(1);

    fsm_state_t state, state_next;

    logic [STATE_W-1:0] s, goal, ns_calc;
    logic [ACT_W-1:0]   act_hold, act_eff;
    logic               act_held;
    logic [HALF-1:0]    cur_x, cur_y, nxt_x, nxt_y;
    logic [CNT_W-1:0]   step_q, epi_q;
    logic               hazard, sb_empty, in_run;
    logic               valid_int, do_issue, run_begin, epi_inc, epi_restart;

    assign in_run  = (state == ST_RUN);
    assign act_eff = act_held ? act_hold : act_rand;

    assign {cur_x, cur_y} = s;

    always_comb begin
        nxt_x = cur_x;
        nxt_y = cur_y;
        case (act_eff)
            ACT_LEFT:  nxt_y = (cur_y == '0) ? cur_y : cur_y - XY_ONE;
            ACT_UP:    nxt_x = (cur_x == '0) ? cur_x : cur_x - XY_ONE;
            ACT_RIGHT: nxt_y = (cur_y == '1) ? cur_y : cur_y + XY_ONE;
            ACT_DOWN:  nxt_x = (cur_x == '1) ? cur_x : cur_x + XY_ONE;
            default:   ;
        endcase
    end

    assign ns_calc = {nxt_x, nxt_y};

    qlearn_hazard_sb #(
        .STATE_W (STATE_W),
        .DEPTH   (PIPE_DEPTH)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .push       (do_issue),
        .push_state (s),
        .s          (s),
        .ns         (ns_calc),
        .hazard     (hazard),
        .empty      (sb_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        valid_int   = 1'b0;
        do_issue    = 1'b0;
        run_begin   = 1'b0;
        epi_inc     = 1'b0;
        epi_restart = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next = ST_RUN;
                    run_begin  = 1'b1;
                end
            end
            ST_RUN: begin
                valid_int = !hazard;
                if (valid_int && issue_ready) begin
                    do_issue = 1'b1;
                    if ((ns_calc == goal) || (step_q == LAST_STEP)) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (sb_empty) begin
                    epi_inc = 1'b1;
                    if (epi_q == LAST_EPI) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next  = ST_RUN;
                        epi_restart = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s        <= '0;
            goal     <= '0;
            step_q   <= '0;
            epi_q    <= '0;
            act_hold <= '0;
            act_held <= 1'b0;
        end else begin
            if (run_begin) begin
                s        <= START_S;
                goal     <= goal_state;
                step_q   <= '0;
                epi_q    <= '0;
                act_held <= 1'b0;
            end
            // Freeze the action once presented so a stalled step stays stable.
            if (do_issue) begin
                s        <= ns_calc;
                act_held <= 1'b0;
                if (step_q != '1) begin
                    step_q <= step_q + CNT_ONE;
                end
            end else if (valid_int && !act_held) begin
                act_hold <= act_rand;
                act_held <= 1'b1;
            end
            if (epi_inc && (epi_q != '1)) begin
                epi_q <= epi_q + CNT_ONE;
            end
            if (epi_restart) begin
                s      <= START_S;
                step_q <= '0;
            end
        end
    end

    assign issue_valid = valid_int;
    assign issue_s     = in_run ? s : '0;
    assign issue_a     = in_run ? act_eff : '0;
    assign issue_ns    = in_run ? ns_calc : '0;
    assign step_cnt    = step_q;
    assign epi_cnt     = epi_q;
    assign busy        = (state == ST_RUN) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);

endmodule

// File: tb/tb_qlearn_episode_ctrl.sv
// Directed bench for qlearn_episode_ctrl: default-parameter instance for
// stepping/stall/backpressure/drain, small instance for full-run completion.
module tb_qlearn_episode_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, start6, ready;
    logic [1:0] act;
    logic [5:0] goal;

    logic       valid, busy, done;
    logic [5:0] is_s, is_ns;
    logic [1:0] is_a;
    logic [7:0] step, epi;

    logic       valid6, busy6, done6;
    logic [5:0] is_s6, is_ns6;
    logic [1:0] is_a6;
    logic [7:0] step6, epi6;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qlearn_episode_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .goal_state(goal), .act_rand(act),
        .issue_ready(ready), .issue_valid(valid), .issue_s(is_s), .issue_a(is_a),
        .issue_ns(is_ns), .step_cnt(step), .epi_cnt(epi), .busy(busy), .done(done)
    );

    qlearn_episode_ctrl #(
        .NUM_EPIS  (2),
        .MAX_STEPS (3)
    ) dut6 (
        .clk(clk), .rst(rst), .start(start6), .goal_state(goal), .act_rand(act),
        .issue_ready(ready), .issue_valid(valid6), .issue_s(is_s6), .issue_a(is_a6),
        .issue_ns(is_ns6), .step_cnt(step6), .epi_cnt(epi6), .busy(busy6), .done(done6)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; start6 = 1'b0; ready = 1'b0; act = 2'd3; goal = '0;
        tick; tick;
        rst = 1'b0;

        chk_eq("rst_valid", 32'(valid), 0);
        chk_eq("rst_busy",  32'(busy), 0);
        chk_eq("rst_done",  32'(done), 0);
        chk_eq("rst_step",  32'(step), 0);
        chk_eq("rst_epi",   32'(epi), 0);
        chk_eq("rst_ns",    32'(is_ns), 0);

        // Wall clamp from s=0, checked combinationally before the action freezes
        goal = 6'h3f; act = 2'b00; start = 1'b1;
        tick;
        start = 1'b0;
        chk_eq("t2_busy",     32'(busy), 1);
        chk_eq("t2_valid",    32'(valid), 1);
        chk_eq("t2_ns_left",  32'(is_ns), 0);
        act = 2'b01; #1;
        chk_eq("t2_ns_up",    32'(is_ns), 0);
        act = 2'b10; #1;
        chk_eq("t2_ns_right", 32'(is_ns), 1);

        // Backpressure: ready low for three cycles, action held at RIGHT
        tick;
        act = 2'b00;
        for (int i = 0; i < 2; i++) begin
            chk_eq("t4_valid", 32'(valid), 1);
            chk_eq("t4_s",     32'(is_s), 0);
            chk_eq("t4_a",     32'(is_a), 2);
            chk_eq("t4_ns",    32'(is_ns), 1);
            chk_eq("t4_step",  32'(step), 0);
            if (i == 1) ready = 1'b1;
            tick;
        end

        // Hazard: s=1 moving left to 0, which is still in flight
        for (int i = 0; i < 4; i++) begin
            chk_eq("t3_stall", 32'(valid), 0);
            chk_eq("t3_step",  32'(step), 1);
            tick;
        end
        chk_eq("t3_valid", 32'(valid), 1);
        chk_eq("t3_s",     32'(is_s), 1);
        chk_eq("t3_ns",    32'(is_ns), 0);
        chk_eq("t3_a",     32'(is_a), 0);
        tick;

        // Reset mid-run
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        chk_eq("t1_valid", 32'(valid), 0);
        chk_eq("t1_busy",  32'(busy), 0);
        chk_eq("t1_step",  32'(step), 0);
        chk_eq("t1_epi",   32'(epi), 0);
        chk_eq("t1_done",  32'(done), 0);

        // Termination at goal=2 moving right from 0
        goal = 6'd2; act = 2'b10; ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chk_eq("t1_sb_clear", 32'(valid), 1);
        chk_eq("t5_s0",       32'(is_s), 0);
        chk_eq("t5_ns0",      32'(is_ns), 1);
        tick;
        chk_eq("t5_valid1", 32'(valid), 1);
        chk_eq("t5_s1",     32'(is_s), 1);
        chk_eq("t5_ns1",    32'(is_ns), 2);
        chk_eq("t5_step1",  32'(step), 1);
        tick;
        for (int i = 0; i < 4; i++) begin
            chk_eq("t5_drain_valid", 32'(valid), 0);
            chk_eq("t5_drain_busy",  32'(busy), 1);
            chk_eq("t5_drain_epi",   32'(epi), 0);
            chk_eq("t5_drain_step",  32'(step), 2);
            tick;
        end
        chk_eq("t5_rerun_valid", 32'(valid), 1);
        chk_eq("t5_rerun_epi",   32'(epi), 1);
        chk_eq("t5_rerun_step",  32'(step), 0);
        chk_eq("t5_rerun_s",     32'(is_s), 0);

        // Full run on the small instance: 2 episodes of 3 steps
        ready = 1'b0; rst = 1'b1;
        tick; tick;
        rst = 1'b0; goal = 6'h3f; act = 2'b10; ready = 1'b1; start6 = 1'b1;
        tick;
        start6 = 1'b0;
        for (int ep = 0; ep < 2; ep++) begin
            for (int k = 0; k < 3; k++) begin
                chk_eq("t6_valid", 32'(valid6), 1);
                chk_eq("t6_s",     32'(is_s6), 32'(k));
                chk_eq("t6_ns",    32'(is_ns6), 32'(k + 1));
                chk_eq("t6_step",  32'(step6), 32'(k));
                chk_eq("t6_epi",   32'(epi6), 32'(ep));
                tick;
            end
            for (int d = 0; d < 4; d++) begin
                chk_eq("t6_drain_valid", 32'(valid6), 0);
                chk_eq("t6_drain_busy",  32'(busy6), 1);
                chk_eq("t6_drain_done",  32'(done6), 0);
                tick;
            end
        end
        chk_eq("t6_done",       32'(done6), 1);
        chk_eq("t6_done_busy",  32'(busy6), 0);
        chk_eq("t6_done_epi",   32'(epi6), 2);
        chk_eq("t6_done_step",  32'(step6), 3);
        chk_eq("t6_done_valid", 32'(valid6), 0);
        tick;
        chk_eq("t6_hold_done", 32'(done6), 1);

        start6 = 1'b1;
        tick;
        start6 = 1'b0;
        chk_eq("t6_restart_busy",  32'(busy6), 1);
        chk_eq("t6_restart_done",  32'(done6), 0);
        chk_eq("t6_restart_epi",   32'(epi6), 0);
        chk_eq("t6_restart_step",  32'(step6), 0);
        chk_eq("t6_restart_valid", 32'(valid6), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
